// File: rtl/seg_scan_driver.sv
// Multiplexed scan driver for a common-anode seven-segment display with blanking gaps
// between digits and frame-aligned commit of newly loaded digit values.
module seg_scan_driver #(
    parameter int NUM_DIGITS      = 2,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [4*NUM_DIGITS-1:0]       digit_val,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          load,
    output logic                          load_ack,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    cathode,
    output logic                          frame_tick,
    output logic [$clog2(NUM_DIGITS)-1:0] cur_digit
);

    localparam int CUR_W     = $clog2(NUM_DIGITS);
    localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CUR_W-1:0] CUR_LAST   = CUR_W'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [CUR_W-1:0]        cur_reg, cur_next;
    logic [4*NUM_DIGITS-1:0] val_reg, val_next, pend_val_reg;
    logic [NUM_DIGITS-1:0]   en_reg, en_next, pend_en_reg;
    logic                    pend_flag_reg;
    logic                    load_ack_reg;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic [6:0]              cathode_reg, cathode_next;
    logic                    frame_end;
    logic                    commit;
    logic [3:0]              nib_arr [NUM_DIGITS];

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        cur_next   = cur_reg;
        case (state_reg)
            BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                end
            end
            DRIVE: begin
                if (cnt_reg == DRIVE_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    cur_next   = (cur_reg == CUR_LAST) ? '0 : cur_reg + 1'b1;
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    assign frame_end = (state_reg == DRIVE) && (cnt_reg == DRIVE_LAST) && (cur_reg == CUR_LAST);
    assign commit    = frame_end && pend_flag_reg;
    assign val_next  = commit ? pend_val_reg : val_reg;
    assign en_next   = commit ? pend_en_reg  : en_reg;

    // Outputs are precomputed from next-state values so they register on the state edge.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = val_next[4*gi +: 4];
            assign an_next[gi] = !((state_next == DRIVE) && en_next[gi] &&
                                   (cur_next == CUR_W'(gi)));
        end
    endgenerate

    always_comb begin
        cathode_next = 7'b111_1111;
        if ((state_next == DRIVE) && en_next[cur_next]) begin
            cathode_next = seg_decode(nib_arr[cur_next]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= BLANK;
            cnt_reg       <= '0;
            cur_reg       <= '0;
            val_reg       <= '0;
            en_reg        <= '0;
            pend_val_reg  <= '0;
            pend_en_reg   <= '0;
            pend_flag_reg <= 1'b0;
            load_ack_reg  <= 1'b0;
            an_reg        <= '1;
            cathode_reg   <= 7'b111_1111;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cur_reg      <= cur_next;
            val_reg      <= val_next;
            en_reg       <= en_next;
            an_reg       <= an_next;
            cathode_reg  <= cathode_next;
            load_ack_reg <= commit;
            // A load coinciding with commit stays pending for the following frame.
            if (load) begin
                pend_val_reg <= digit_val;
                pend_en_reg  <= digit_en;
            end
            pend_flag_reg <= load || (pend_flag_reg && !commit);
        end
    end

    assign load_ack   = load_ack_reg;
    assign an         = an_reg;
    assign cathode    = cathode_reg;
    assign frame_tick = frame_end;
    assign cur_digit  = cur_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (2 digits, 4 drive ticks, 2 blank ticks):
// stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_seg_scan_driver;

    logic       clock;
    logic       reset_n;
    logic [7:0] digit_val;
    logic [1:0] digit_en;
    logic       load;
    logic       load_ack;
    logic [1:0] an;
    logic [6:0] cathode;
    logic       frame_tick;
    logic       cur_digit;

    seg_scan_driver #(
        .NUM_DIGITS     (2),
        .TICKS_PER_DIGIT(4),
        .BLANK_TICKS    (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .digit_val (digit_val),
        .digit_en  (digit_en),
        .load      (load),
        .load_ack  (load_ack),
        .an        (an),
        .cathode   (cathode),
        .frame_tick(frame_tick),
        .cur_digit (cur_digit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         t;
        logic [1:0] an;
        logic [6:0] cath;
        logic       ft;
        logic       ack;
        logic       cur;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] dec_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference state, advanced in terms of cycles since reset release.
    bit         m_valid = 0;
    int         m_t;
    logic       m_ack, m_pflag;
    logic [7:0] m_pval, m_dval;
    logic [1:0] m_pen, m_den;

    task automatic model_reset();
        m_valid = 1; m_t = 0; m_ack = 0; m_pflag = 0;
        m_pval = '0; m_dval = '0; m_pen = '0; m_den = '0;
    endtask

    task automatic push_expected();
        exp_t e;
        int p, dig, pos;
        p   = m_t % 12;
        dig = p / 6;
        pos = p % 6;
        e.t = m_t; e.an = 2'b11; e.cath = 7'h7F;
        e.ft = (p == 11); e.ack = m_ack; e.cur = (dig == 1);
        if (pos >= 2 && m_den[dig]) begin
            e.an[dig] = 1'b0;
            e.cath    = dec_tab[m_dval[dig*4 +: 4]];
        end
        q.push_back(e);
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] v, input logic [1:0] en);
        logic commit;
        commit = ((m_t % 12) == 11) && m_pflag;
        m_ack  = commit;
        if (commit) begin
            m_dval = m_pval;
            m_den  = m_pen;
        end
        if (ld) begin
            m_pval = v; m_pen = en; m_pflag = 1;
        end else if (commit) begin
            m_pflag = 0;
        end
        m_t++;
    endtask

    task automatic step(input logic rn, input logic ld, input logic [7:0] v, input logic [1:0] en);
        reset_n = rn; load = ld; digit_val = v; digit_en = en;
        if (m_valid) push_expected();
        @(posedge clock);
        #1;
        if (!rn) model_reset();
        else model_edge(ld, v, en);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 2'b00);
    endtask

    // Runs n cycles from frame start with up to two loads at given cycle indices.
    task automatic run(input int n, input int c1, input logic [7:0] v1, input logic [1:0] e1,
                       input int c2, input logic [7:0] v2, input logic [1:0] e2);
        for (int c = 0; c < n; c++) begin
            if (c == c1) step(1'b1, 1'b1, v1, e1);
            else if (c == c2) step(1'b1, 1'b1, v2, e2);
            else step(1'b1, 1'b0, 8'h00, 2'b00);
        end
    endtask

    task automatic chk(input string name, input int t, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, t, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("an",         e.t, {5'b0, an},         {5'b0, e.an});
            chk("cathode",    e.t, cathode,            e.cath);
            chk("frame_tick", e.t, {6'b0, frame_tick}, {6'b0, e.ft});
            chk("load_ack",   e.t, {6'b0, load_ack},   {6'b0, e.ack});
            chk("cur_digit",  e.t, {6'b0, cur_digit},  {6'b0, e.cur});
            $display("cycle=%0d an=%b cathode=%b frame_tick=%b load_ack=%b cur_digit=%0d",
                     e.t, an, cathode, frame_tick, load_ack, cur_digit);
        end
    end

    initial begin
        reset_n = 1'b0; load = 1'b0; digit_val = '0; digit_en = '0;

        do_reset();
        run(24, -1, 8'h00, 2'b00, -1, 8'h00, 2'b00);

        do_reset();
        run(36, 1, 8'h21, 2'b11, -1, 8'h00, 2'b00);

        do_reset();
        run(24, 1, 8'h21, 2'b01, -1, 8'h00, 2'b00);

        do_reset();
        run(24, 2, 8'h34, 2'b11, 5, 8'h56, 2'b11);

        do_reset();
        run(36, 1, 8'h9A, 2'b11, 11, 8'hBC, 2'b11);

        do_reset();
        run(3, 1, 8'h77, 2'b11, -1, 8'h00, 2'b00);
        step(1'b0, 1'b0, 8'h00, 2'b00);
        step(1'b0, 1'b0, 8'h00, 2'b00);
        run(24, -1, 8'h00, 2'b00, -1, 8'h00, 2'b00);

        do_reset();
        for (int v = 0; v < 17; v++) begin
            logic [3:0] nib;
            nib = v[3:0];
            run(12, (v < 16) ? 1 : -1, {4'h0, nib}, 2'b01, -1, 8'h00, 2'b00);
        end

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
